l2_full_connect: RTL and testbench

//  Second fully-connected layer, directly downstream of the L1 full-connect stage.

---
 rtl/l2fc_pkg.sv | 20 ++
 rtl/l2fc_mac.sv | 45 ++++
 rtl/l2_full_connect.sv | 121 ++++++++++++
 tb/tb_l2_full_connect.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2fc_pkg.sv
// Shared types and sizes for the second fully-connected layer.
package l2fc_pkg;

    localparam int IN_NUM  = 16;
    localparam int NEU_NUM = 10;
    localparam int ACC_W   = 24;

    typedef logic [3:0] idx_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        MAC,
        BIAS,
        CMP,
        OUT
    } state_t;

endpackage

// File: rtl/l2fc_mac.sv
// Purpose: 8-bit unsigned x 8-bit signed multiply-accumulate with bias add.
// Latency: one product or bias folded into acc per enabled cycle.
// Backpressure: none; the caller sequences clear/en/add_bias.
module l2fc_mac
    import l2fc_pkg::*;
#(
    parameter int BIAS_SHIFT = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    add_bias,
    input  logic                    en,
    input  logic [7:0]              act,
    input  logic signed [7:0]       w,
    input  logic signed [7:0]       bias,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [16:0]      act_ext;
    logic signed [16:0]      w_ext;
    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;

    // 17x17 signed multiply; the true product always fits in 17 bits
    assign act_ext  = {9'b0, act};
    assign w_ext    = {{9{w[7]}}, w};
    assign prod     = act_ext * w_ext;
    assign prod_ext = {{(ACC_W-17){prod[16]}}, prod};
    assign bias_ext = {{(ACC_W-8-BIAS_SHIFT){bias[7]}}, bias, {BIAS_SHIFT{1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add_bias) begin
            acc <= acc + bias_ext;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/l2_full_connect.sv
// Purpose: second FC layer; 16 activations x NEU_NUM neurons, biased sums, running argmax.
// Latency: 20 cycles per neuron, out_valid 200 cycles after the accepting edge.
// Backpressure: in_ready only in IDLE; result held on out_valid until out_ready.
module l2_full_connect
    import l2fc_pkg::*;
#(
    parameter int WEIGHT_BASE = 0,
    parameter int BIAS_SHIFT  = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            din,
    output logic [8:0]              weight_addr,
    input  logic [127:0]            weight_data,
    input  logic [7:0]              bias_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              class_idx,
    output logic signed [ACC_W-1:0] class_score
);

    localparam logic signed [ACC_W-1:0] SCORE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state;
    state_t                  state_nxt;
    logic [127:0]            act_reg;
    logic [127:0]            w_reg;
    logic signed [7:0]       b_reg;
    logic [3:0]              k_cnt;
    idx_t                    n_cnt;
    idx_t                    best_idx;
    logic signed [ACC_W-1:0] best_score;
    logic signed [ACC_W-1:0] acc;
    logic [7:0]              act_sel;
    logic signed [7:0]       w_sel;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == OUT);
    assign class_idx   = best_idx;
    assign class_score = best_score;
    assign weight_addr = 9'(WEIGHT_BASE) + 9'(n_cnt);
    assign act_sel     = act_reg[{k_cnt, 3'b000} +: 8];
    assign w_sel       = w_reg[{k_cnt, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = MAC;
            MAC:     if (k_cnt == 4'(IN_NUM-1)) state_nxt = BIAS;
            BIAS:    state_nxt = CMP;
            CMP:     state_nxt = (n_cnt == idx_t'(NEU_NUM-1)) ? OUT : FETCH;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_reg    <= '0;
            w_reg      <= '0;
            b_reg      <= '0;
            k_cnt      <= '0;
            n_cnt      <= '0;
            best_idx   <= '0;
            best_score <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        act_reg    <= din;
                        n_cnt      <= '0;
                        best_idx   <= '0;
                        best_score <= SCORE_MIN;
                    end
                end
                WAIT: begin
                    w_reg <= weight_data;
                    b_reg <= bias_data;
                    k_cnt <= '0;
                end
                MAC: k_cnt <= k_cnt + 4'd1;
                CMP: begin
                    // strict compare keeps the lower index on ties
                    if (acc > best_score) begin
                        best_score <= acc;
                        best_idx   <= n_cnt;
                    end
                    if (n_cnt != idx_t'(NEU_NUM-1)) n_cnt <= n_cnt + idx_t'(1);
                end
                default: ;
            endcase
        end
    end

    l2fc_mac #(
        .BIAS_SHIFT (BIAS_SHIFT)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == WAIT),
        .add_bias (state == BIAS),
        .en       (state == MAC),
        .act      (act_sel),
        .w        (w_sel),
        .bias     (b_reg),
        .acc      (acc)
    );

endmodule

// File: tb/tb_l2_full_connect.sv
// Self-checking bench for l2_full_connect: directed table, random vectors against an arithmetic argmax model.
module tb_l2_full_connect;
    import l2fc_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [127:0]            din;
    logic [8:0]              weight_addr;
    logic [127:0]            weight_data;
    logic [7:0]              bias_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [3:0]              class_idx;
    logic signed [ACC_W-1:0] class_score;

    typedef struct {
        logic [127:0]       din;
        logic [9:0][127:0]  w;
        logic [9:0][7:0]    b;
        int                 exp_idx;
        int                 exp_score;
    } vec_t;

    vec_t cur;
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    l2_full_connect dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din         (din),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .bias_data   (bias_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    // Synchronous ROM, one cycle read latency
    always @(posedge clk) begin
        if (weight_addr < 9'(NEU_NUM)) begin
            weight_data <= cur.w[weight_addr[3:0]];
            bias_data   <= cur.b[weight_addr[3:0]];
        end else begin
            weight_data <= '0;
            bias_data   <= '0;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: biased dot product per neuron, first maximum wins
    task automatic model(input vec_t v, output int idx, output int score);
        int s;
        idx   = 0;
        score = 0;
        for (int n = 0; n < NEU_NUM; n++) begin
            s = int'($signed(v.b[n])) * 128;
            for (int k = 0; k < IN_NUM; k++)
                s += int'(v.din[8*k +: 8]) * int'($signed(v.w[n][8*k +: 8]));
            if (n == 0 || s > score) begin
                score = s;
                idx   = n;
            end
        end
    endtask

    function automatic vec_t zero_vec();
        vec_t z;
        z.din = '0;
        z.w = '0;
        z.b = '0;
        z.exp_idx = 0;
        z.exp_score = 0;
        return z;
    endfunction

    task automatic start_run(input logic [127:0] d, input string tag);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " in_ready before accept"}, in_ready, 1);
        in_valid = 1'b1;
        din      = d;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " busy after accept"}, in_ready, 0);
    endtask

    task automatic wait_out(input bit noise, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 400) begin
            if (noise && cyc < 180) begin
                in_valid = 1'($urandom_range(0, 1));
                din      = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit noise);
        int cyc;
        cur = v;
        start_run(v.din, tag);
        wait_out(noise, cyc);
        chk({tag, " latency"}, cyc, 200);
        chk({tag, " class_idx"}, class_idx, v.exp_idx);
        chk({tag, " class_score"}, longint'(class_score), v.exp_score);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, out_valid, 0);
        chk({tag, " in_ready back"}, in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   cyc;
        int   m_idx;
        int   m_score;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        cur       = zero_vec();

        // Directed table with hand-computed expectations
        v = zero_vec();
        v.din = {16{8'h01}};
        v.w[3] = {16{8'h01}};
        v.exp_idx = 3; v.exp_score = 16;
        vecs.push_back(v);

        v = zero_vec();
        v.din = 128'hFF;
        for (int n = 0; n < NEU_NUM; n++) v.w[n] = 128'h80;
        v.b[7] = 8'h01;
        v.exp_idx = 7; v.exp_score = -32512;
        vecs.push_back(v);

        v = zero_vec();
        v.din = {16{8'h10}};
        for (int n = 0; n < NEU_NUM; n++) begin
            v.w[n] = {16{8'h05}};
            v.b[n] = 8'h03;
        end
        v.exp_idx = 0; v.exp_score = 1664;
        vecs.push_back(v);

        v = zero_vec();
        for (int n = 0; n < NEU_NUM; n++) v.b[n] = 8'(n - 5);
        v.w[2] = {16{8'h7F}};
        v.exp_idx = 9; v.exp_score = 512;
        vecs.push_back(v);

        v = zero_vec();
        for (int n = 0; n < NEU_NUM; n++) v.b[n] = 8'h80;
        v.exp_idx = 0; v.exp_score = -16384;
        vecs.push_back(v);

        v = zero_vec();
        v.din = {16{8'hFF}};
        v.w[5] = {16{8'h7F}};
        v.b[5] = 8'h7F;
        v.exp_idx = 5; v.exp_score = 534416;
        vecs.push_back(v);

        // Random vectors, expectations from the model
        for (int i = 0; i < 6; i++) begin
            v = zero_vec();
            v.din = {$urandom, $urandom, $urandom, $urandom};
            for (int n = 0; n < NEU_NUM; n++) begin
                v.w[n] = {$urandom, $urandom, $urandom, $urandom};
                v.b[n] = 8'($urandom);
            end
            if (i == 2) begin
                v.w[8] = v.w[1];
                v.b[8] = v.b[1];
            end
            model(v, m_idx, m_score);
            v.exp_idx = m_idx;
            v.exp_score = m_score;
            vecs.push_back(v);
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset class_idx", class_idx, 0);
        chk("reset class_score", longint'(class_score), 0);
        for (int c = 0; c < 50; c++) begin
            chk("idle out_valid", out_valid, 0);
            chk("idle in_ready", in_ready, 1);
            chk("idle weight_addr", weight_addr, 0);
            @(negedge clk);
        end

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i), bit'(i % 2));

        // Output held under backpressure; in_valid during the final OUT cycle is ignored
        cur = vecs[0];
        start_run(vecs[0].din, "hold");
        wait_out(1'b0, cyc);
        chk("hold latency", cyc, 200);
        for (int c = 0; c < 30; c++) begin
            chk("hold out_valid", out_valid, 1);
            chk("hold in_ready", in_ready, 0);
            chk("hold class_idx", class_idx, 3);
            chk("hold class_score", longint'(class_score), 16);
            @(negedge clk);
        end
        cur       = vecs[1];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din       = vecs[1].din;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("hold release out_valid", out_valid, 0);
        chk("hold release not accepted", in_ready, 1);
        run_vec(vecs[1], "second", 1'b0);

        // Reset in the middle of neuron 5's MAC phase
        cur = vecs[0];
        start_run(vecs[0].din, "abort");
        repeat (105) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort out_valid", out_valid, 0);
        chk("abort in_ready", in_ready, 1);
        chk("abort class_score", longint'(class_score), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], "after_abort", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
